// File: rtl/des_key_schedule_if.sv
// Signal bundle between des_key_schedule and its neighbours: key load plus the C/D pair handshake.
// The decrypt member exists only when DES_DECRYPT_EN is defined.
interface des_key_schedule_if;
  logic        start;
  logic [64:1] key_in;
  logic        busy;
  logic        done;
  logic        cd_valid;
  logic        cd_ready;
  logic [28:1] c_out;
  logic [28:1] d_out;
  logic [4:0]  round_num;
`ifdef DES_DECRYPT_EN
  logic        decrypt;

  // master: the key schedule itself; slave: controller + PC-2 consumer side
  modport master (
    input  start, key_in, cd_ready, decrypt,
    output busy, done, cd_valid, c_out, d_out, round_num
  );
  modport slave (
    output start, key_in, cd_ready, decrypt,
    input  busy, done, cd_valid, c_out, d_out, round_num
  );
`else
  modport master (
    input  start, key_in, cd_ready,
    output busy, done, cd_valid, c_out, d_out, round_num
  );
  modport slave (
    output start, key_in, cd_ready,
    input  busy, done, cd_valid, c_out, d_out, round_num
  );
`endif
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule front end: PC-1, then 16 rounds of C/D rotation behind a valid/ready pair.
// Optional DES_DECRYPT_EN adds a decrypt input that presents the pairs in reverse (K16..K1) order.
module des_key_schedule #(
  parameter logic [15:0] SHIFT2_MASK = 16'h7EFC
) (
  input logic              clk,
  input logic              rst_n,
  des_key_schedule_if.master kbus
);

  typedef enum logic {S_IDLE, S_ROUND} state_t;
  typedef logic [28:1] half_t;

  // FIPS-order rotations: bit 1 is the leftmost bit, so "left" moves bits toward index 1.
  function automatic half_t rotl1(input half_t x);
    return {x[1], x[28:2]};
  endfunction

  function automatic half_t rotl(input half_t x, input logic two);
    return two ? rotl1(rotl1(x)) : rotl1(x);
  endfunction

`ifdef DES_DECRYPT_EN
  function automatic half_t rotr1(input half_t x);
    return {x[27:1], x[28]};
  endfunction

  function automatic half_t rotr(input half_t x, input logic two);
    return two ? rotr1(rotr1(x)) : rotr1(x);
  endfunction
`endif

  state_t      state_q, state_d;
  half_t       c_q, c_d, d_q, d_d;
  logic [4:0]  round_q, round_d;
  logic        done_q, done_d;
  logic [64:1] key;
  half_t       key_c, key_d;
  logic        enc_two;
`ifdef DES_DECRYPT_EN
  logic        dec_q, dec_d;
  logic        dec_two;
`endif

  assign key = kbus.key_in;

  // PC-1, listed from C/D bit 28 down to bit 1; parity bits 8,16..64 never appear.
  assign key_c = {key[36], key[44], key[52], key[60], key[3],  key[11], key[19],
                  key[27], key[35], key[43], key[51], key[59], key[2],  key[10],
                  key[18], key[26], key[34], key[42], key[50], key[58], key[1],
                  key[9],  key[17], key[25], key[33], key[41], key[49], key[57]};
  assign key_d = {key[4],  key[12], key[20], key[28], key[5],  key[13], key[21],
                  key[29], key[37], key[45], key[53], key[61], key[6],  key[14],
                  key[22], key[30], key[38], key[46], key[54], key[62], key[7],
                  key[15], key[23], key[31], key[39], key[47], key[55], key[63]};

  // Amount for the next round r+1 lives in mask bit r; decrypt uses encrypt round 17-r, bit 16-r.
  assign enc_two = SHIFT2_MASK[round_q[3:0]];
`ifdef DES_DECRYPT_EN
  assign dec_two = SHIFT2_MASK[4'd0 - round_q[3:0]];
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    done_d  = 1'b0;
`ifdef DES_DECRYPT_EN
    dec_d   = dec_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (kbus.start) begin
`ifdef DES_DECRYPT_EN
          dec_d = kbus.decrypt;
          if (kbus.decrypt) begin
            c_d = key_c;
            d_d = key_d;
          end else begin
            c_d = rotl(key_c, SHIFT2_MASK[0]);
            d_d = rotl(key_d, SHIFT2_MASK[0]);
          end
`else
          c_d = rotl(key_c, SHIFT2_MASK[0]);
          d_d = rotl(key_d, SHIFT2_MASK[0]);
`endif
          round_d = 5'd1;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (kbus.cd_ready) begin
          if (round_q == 5'd16) begin
            round_d = 5'd0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            round_d = round_q + 5'd1;
`ifdef DES_DECRYPT_EN
            if (dec_q) begin
              c_d = rotr(c_q, dec_two);
              d_d = rotr(d_q, dec_two);
            end else begin
              c_d = rotl(c_q, enc_two);
              d_d = rotl(d_q, enc_two);
            end
`else
            c_d = rotl(c_q, enc_two);
            d_d = rotl(d_q, enc_two);
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= 5'd0;
      done_q  <= 1'b0;
`ifdef DES_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      done_q  <= done_d;
`ifdef DES_DECRYPT_EN
      dec_q   <= dec_d;
`endif
    end
  end

  // Every ROUND cycle holds a valid pair, so valid and busy both follow the state.
  assign kbus.busy      = (state_q == S_ROUND);
  assign kbus.cd_valid  = (state_q == S_ROUND);
  assign kbus.c_out     = c_q;
  assign kbus.d_out     = d_q;
  assign kbus.round_num = round_q;
  assign kbus.done      = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: table-driven DES key model checked every cycle,
// pinned by the FIPS worked example for key 133457799BBCDFF1.
module tb_des_key_schedule;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0123456789ABCDEF;

  localparam int PC1_C [1:28] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                  10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36};
  localparam int PC1_D [1:28] = '{63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                  14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [1:48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int AMT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic clk;
  logic rst_n;
  des_key_schedule_if kbus ();

  des_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kbus  (kbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests;
  int          fails;
  bit          mon_en;
  int          m_round;
  bit          m_done;
  bit          m_hold;
  bit          m_dec;
  logic [63:0] m_key;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hex values are in FIPS order (leftmost digit = bit 1); ports index bit i at position i.
  function automatic logic [63:0] to_port64(input logic [63:0] h);
    logic [63:0] r;
    r = {<<{h}};
    return r;
  endfunction

  function automatic logic [63:0] to_hex64(input logic [64:1] v);
    logic [63:0] r;
    r = {<<{v}};
    return r;
  endfunction

  function automatic logic [27:0] to_hex28(input logic [28:1] v);
    logic [27:0] r;
    r = {<<{v}};
    return r;
  endfunction

  // Pair for presentation round p: PC-1 halves rotated left by the cumulative shift total.
  function automatic logic [55:0] model_cd(input logic [63:0] k, input int p, input bit dec);
    logic [27:0] c0, d0, c, d;
    int s, last, src;
    s = 0;
    last = dec ? 17 - p : p;
    for (int r = 1; r <= last; r++) s += AMT[r];
    s = s % 28;
    for (int i = 1; i <= 28; i++) begin
      c0[28-i] = k[64-PC1_C[i]];
      d0[28-i] = k[64-PC1_D[i]];
    end
    for (int i = 1; i <= 28; i++) begin
      src = ((i - 1 + s) % 28) + 1;
      c[28-i] = c0[28-src];
      d[28-i] = d0[28-src];
    end
    return {c, d};
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    for (int j = 1; j <= 48; j++) k[48-j] = cd[56-PC2[j]];
    return k;
  endfunction

  // Transaction-level model: which round is on offer, and whether DONE is due.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_round <= 0;
      m_done  <= 1'b0;
      m_hold  <= 1'b0;
      m_dec   <= 1'b0;
      m_key   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_round == 0) begin
        if (kbus.start) begin
          m_round <= 1;
          m_key   <= to_hex64(kbus.key_in);
`ifdef DES_DECRYPT_EN
          m_dec   <= kbus.decrypt;
`else
          m_dec   <= 1'b0;
`endif
        end
      end else if (kbus.cd_ready) begin
        if (m_round == 16) begin
          m_round <= 0;
          m_done  <= 1'b1;
          m_hold  <= 1'b1;
        end else begin
          m_round <= m_round + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [55:0] exp_cd;
    logic [27:0] c_hex, d_hex;
    if (mon_en && rst_n) begin
      c_hex = to_hex28(kbus.c_out);
      d_hex = to_hex28(kbus.d_out);
      check("round_num", 64'(kbus.round_num), 64'(m_round));
      check("busy", 64'(kbus.busy), 64'(m_round != 0));
      check("cd_valid", 64'(kbus.cd_valid), 64'(m_round != 0));
      check("done", 64'(kbus.done), 64'(m_done));
      if (m_round != 0)  exp_cd = model_cd(m_key, m_round, m_dec);
      else if (m_hold)   exp_cd = model_cd(m_key, 16, m_dec);
      else               exp_cd = '0;
      check("c_out", 64'(c_hex), 64'(exp_cd[55:28]));
      check("d_out", 64'(d_hex), 64'(exp_cd[27:0]));
      if (m_key == KEY_A && m_round == 1) begin
        if (!m_dec) begin
          check("r1_c_lit", 64'(c_hex), 64'(28'hE19955F));
          check("r1_d_lit", 64'(d_hex), 64'(28'hAACCF1E));
          check("r1_subkey", 64'(pc2({c_hex, d_hex})), 64'(48'h1B02EFFC7072));
        end else begin
          check("dec_r1_c_lit", 64'(c_hex), 64'(28'hF0CCAAF));
          check("dec_r1_d_lit", 64'(d_hex), 64'(28'h556678F));
          check("dec_r1_subkey", 64'(pc2({c_hex, d_hex})), 64'(48'hCB3D8B0E17F5));
        end
      end
      if (m_key == KEY_A && m_round == 16) begin
        if (!m_dec) begin
          check("r16_c_lit", 64'(c_hex), 64'(28'hF0CCAAF));
          check("r16_d_lit", 64'(d_hex), 64'(28'h556678F));
          check("r16_subkey", 64'(pc2({c_hex, d_hex})), 64'(48'hCB3D8B0E17F5));
        end else begin
          check("dec_r16_c_lit", 64'(c_hex), 64'(28'hE19955F));
          check("dec_r16_d_lit", 64'(d_hex), 64'(28'hAACCF1E));
        end
      end
    end
  end

  // Drive START for one cycle; returns at the negedge where round 1 should be on offer.
  task automatic start_run(input logic [63:0] k);
    kbus.key_in = to_port64(k);
    kbus.start  = 1'b1;
    @(negedge clk);
    kbus.start  = 1'b0;
  endtask

  // round 0 means "wait for DONE"; the bound turns a hang into a counted failure.
  task automatic wait_for(input string what, input int round, input int budget, output int cycles);
    cycles = 0;
    while (!(round == 0 ? kbus.done : (int'(kbus.round_num) == round)) && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (!(round == 0 ? kbus.done : (int'(kbus.round_num) == round))) begin
      tests++;
      fails++;
      $display("FAIL timeout_%s: waited %0d cycles, round_num=%0d", what, cycles, kbus.round_num);
    end
  endtask

  initial begin : stim
    int n;
    logic [27:0] c_snap, d_snap;
    logic [55:0] cd_pin;
    tests  = 0;
    fails  = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    kbus.start    = 1'b0;
    kbus.key_in   = '0;
    kbus.cd_ready = 1'b1;
`ifdef DES_DECRYPT_EN
    kbus.decrypt  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_round", 64'(kbus.round_num), 64'd0);
    check("rst_busy", 64'(kbus.busy), 64'd0);
    check("rst_valid", 64'(kbus.cd_valid), 64'd0);
    check("rst_done", 64'(kbus.done), 64'd0);
    check("rst_c", 64'(kbus.c_out), 64'd0);
    check("rst_d", 64'(kbus.d_out), 64'd0);

    cd_pin = model_cd(KEY_A, 1, 1'b0);
    check("model_r1", 64'(cd_pin), 64'({28'hE19955F, 28'hAACCF1E}));
    cd_pin = model_cd(KEY_A, 16, 1'b0);
    check("model_r16", 64'(cd_pin), 64'({28'hF0CCAAF, 28'h556678F}));
    cd_pin = model_cd(KEY_A, 1, 1'b0);
    check("model_k1", 64'(pc2(cd_pin)), 64'(48'h1B02EFFC7072));

    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Uninterrupted encrypt run, DONE latency measured from the START cycle.
    start_run(KEY_A);
    wait_for("done_run1", 0, 40, n);
    check("done_latency", 64'(n + 1), 64'd17);

    // START in the DONE cycle, then a 5-cycle stall at round 3.
    start_run(KEY_A);
    check("b2b_round", 64'(kbus.round_num), 64'd1);
    wait_for("round3", 3, 40, n);
    kbus.cd_ready = 1'b0;
    c_snap = to_hex28(kbus.c_out);
    d_snap = to_hex28(kbus.d_out);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_round", 64'(kbus.round_num), 64'd3);
      check("stall_c", 64'(to_hex28(kbus.c_out)), 64'(c_snap));
      check("stall_d", 64'(to_hex28(kbus.d_out)), 64'(d_snap));
      check("stall_valid", 64'(kbus.cd_valid), 64'd1);
    end
    kbus.cd_ready = 1'b1;
    wait_for("done_run2", 0, 40, n);
    repeat (2) @(negedge clk);

    // START while busy must be ignored.
    start_run(KEY_A);
    wait_for("round7", 7, 40, n);
    kbus.key_in = to_port64(KEY_B);
    kbus.start  = 1'b1;
    @(negedge clk);
    kbus.start  = 1'b0;
    check("ignored_start_round", 64'(kbus.round_num), 64'd8);
    cd_pin = model_cd(KEY_A, 8, 1'b0);
    check("ignored_start_c", 64'(to_hex28(kbus.c_out)), 64'(cd_pin[55:28]));
    wait_for("done_run3", 0, 40, n);
    @(negedge clk);

    // Asynchronous reset in the middle of a run, then a clean restart.
    start_run(KEY_B);
    wait_for("round10", 10, 40, n);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_round", 64'(kbus.round_num), 64'd0);
    check("async_rst_busy", 64'(kbus.busy), 64'd0);
    check("async_rst_valid", 64'(kbus.cd_valid), 64'd0);
    check("async_rst_c", 64'(kbus.c_out), 64'd0);
    check("async_rst_d", 64'(kbus.d_out), 64'd0);
    @(negedge clk);
    check("async_rst_no_done", 64'(kbus.done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(KEY_A);
    check("restart_round", 64'(kbus.round_num), 64'd1);
    wait_for("done_run4", 0, 40, n);

`ifdef DES_DECRYPT_EN
    @(negedge clk);
    kbus.decrypt = 1'b1;
    start_run(KEY_A);
    kbus.decrypt = 1'b0;
    wait_for("done_dec", 0, 40, n);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
